// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// The master drives operands and consumes results; the slave is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
    logic             Zero;
    logic             Ovf;

    modport master (
        output In_Valid, A, B, Bin, Out_Ready,
        input  In_Ready, Out_Valid, Diff, Borrow, Zero, Ovf
    );

    modport slave (
        input  In_Valid, A, B, Bin, Out_Ready,
        output In_Ready, Out_Valid, Diff, Borrow, Zero, Ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: A - B - Bin, DIGIT bits per cycle, LSB first.
// Result and flags are registered and held until the consumer accepts them.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             brw_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;
    logic             ovf_q;
    logic             rdy_q;
    logic             vld_q;

    int               idx;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   sub;
    logic [WIDTH-1:0] diff_d;
    logic             brw_d;
    logic             last;

    // Subtract the current digit and splice it into the running result.
    always_comb begin
        idx    = int'(cnt_q) * DIGIT;
        a_dig  = a_q[idx +: DIGIT];
        b_dig  = b_q[idx +: DIGIT];
        sub    = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_q};
        brw_d  = sub[DIGIT];
        diff_d = diff_q;
        diff_d[idx +: DIGIT] = sub[DIGIT-1:0];
        last   = (cnt_q == CW'(N - 1));
    end

    // Control FSM with registered handshake outputs, operand capture and flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rdy_q && bus.In_Valid) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        brw_q   <= bus.Bin;
                        cnt_q   <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= S_RUN;
                    end else begin
                        // Ready comes up one cycle after reset release.
                        rdy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    diff_q <= diff_d;
                    brw_q  <= brw_d;
                    if (last) begin
                        cnt_q    <= '0;
                        vld_q    <= 1'b1;
                        borrow_q <= brw_d;
                        zero_q   <= (diff_d == '0);
                        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                    (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.Out_Ready) begin
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.In_Ready  = rdy_q;
    assign bus.Out_Valid = vld_q;
    assign bus.Diff      = diff_q;
    assign bus.Borrow    = borrow_q;
    assign bus.Zero      = zero_q;
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at three WIDTH/DIGIT points.
// sel picks which instance the shared stimulus and observed outputs refer to.
module tb_serial_subtractor;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    int          sel = 0;
    logic        in_valid = 1'b0;
    logic [15:0] a_s = '0;
    logic [15:0] b_s = '0;
    logic        bin_s = 1'b0;
    logic        out_ready = 1'b0;

    serial_subtractor_if #(.WIDTH(8))  if0 ();
    serial_subtractor_if #(.WIDTH(16)) if1 ();
    serial_subtractor_if #(.WIDTH(16)) if2 ();

    assign if0.In_Valid  = in_valid && (sel == 0);
    assign if0.A         = a_s[7:0];
    assign if0.B         = b_s[7:0];
    assign if0.Bin       = bin_s;
    assign if0.Out_Ready = out_ready && (sel == 0);

    assign if1.In_Valid  = in_valid && (sel == 1);
    assign if1.A         = a_s;
    assign if1.B         = b_s;
    assign if1.Bin       = bin_s;
    assign if1.Out_Ready = out_ready && (sel == 1);

    assign if2.In_Valid  = in_valid && (sel == 2);
    assign if2.A         = a_s;
    assign if2.B         = b_s;
    assign if2.Bin       = bin_s;
    assign if2.Out_Ready = out_ready && (sel == 2);

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
        .CLK (CLK),
        .RST (RST),
        .bus (if0)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(2)) u1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if1)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u2 (
        .CLK (CLK),
        .RST (RST),
        .bus (if2)
    );

    logic        rdy_m;
    logic        vld_m;
    logic [15:0] diff_m;
    logic        brw_m;
    logic        zero_m;
    logic        ovf_m;

    // Route the selected instance's outputs to common observation signals.
    always_comb begin
        rdy_m  = 1'b0;
        vld_m  = 1'b0;
        diff_m = '0;
        brw_m  = 1'b0;
        zero_m = 1'b0;
        ovf_m  = 1'b0;
        case (sel)
            0: begin
                rdy_m  = if0.In_Ready;
                vld_m  = if0.Out_Valid;
                diff_m = {8'h00, if0.Diff};
                brw_m  = if0.Borrow;
                zero_m = if0.Zero;
                ovf_m  = if0.Ovf;
            end
            1: begin
                rdy_m  = if1.In_Ready;
                vld_m  = if1.Out_Valid;
                diff_m = if1.Diff;
                brw_m  = if1.Borrow;
                zero_m = if1.Zero;
                ovf_m  = if1.Ovf;
            end
            2: begin
                rdy_m  = if2.In_Ready;
                vld_m  = if2.Out_Valid;
                diff_m = if2.Diff;
                brw_m  = if2.Borrow;
                zero_m = if2.Zero;
                ovf_m  = if2.Ovf;
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 2) ? 4 : 8;
    endfunction

    function automatic int width_of(input int s);
        return (s == 0) ? 8 : 16;
    endfunction

    task automatic start_op(input int s, input logic [15:0] a,
                            input logic [15:0] b, input logic bin);
        sel = s;
        #0;
        for (int i = 0; i < 30 && !rdy_m; i++) begin
            @(posedge CLK);
            #1;
        end
        chk("in_ready_wait", rdy_m, 1);
        a_s      = a;
        b_s      = b;
        bin_s    = bin;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int s);
        int cyc;
        cyc = 0;
        while (!vld_m && cyc < 40) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk("latency", cyc, lat_of(s));
        chk("excl", {31'b0, rdy_m & vld_m}, 0);
    endtask

    task automatic release_res();
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        chk("rdy_after_done", rdy_m, 1);
        chk("vld_after_done", vld_m, 0);
    endtask

    task automatic chk_res(input string tag, input logic [15:0] d,
                           input logic bw, input logic z, input logic o);
        chk({tag, ".diff"}, diff_m, d);
        chk({tag, ".borrow"}, brw_m, bw);
        chk({tag, ".zero"}, zero_m, z);
        chk({tag, ".ovf"}, ovf_m, o);
    endtask

    // Reference: integer arithmetic, overflow from the signed range.
    function automatic logic [18:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic bin);
        int          ai, bi, r, sa, sb, sr;
        logic [15:0] m, d;
        logic        bw, z, o;
        ai = int'(a);
        bi = int'(b);
        r  = ai - bi - int'(bin);
        m  = (w == 16) ? 16'hFFFF : 16'h00FF;
        d  = 16'(r) & m;
        bw = (r < 0);
        z  = (d == 16'h0);
        sa = a[w-1] ? ai - (1 << w) : ai;
        sb = b[w-1] ? bi - (1 << w) : bi;
        sr = sa - sb - int'(bin);
        o  = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
        return {o, z, bw, d};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bw;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs [6] = '{
        '{16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0, 1'b0},
        '{16'h03, 16'h05, 1'b0, 16'hFE, 1'b1, 1'b0, 1'b0},
        '{16'h5A, 16'h5A, 1'b0, 16'h00, 1'b0, 1'b1, 1'b0},
        '{16'h5A, 16'h5A, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0},
        '{16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b0, 1'b1},
        '{16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        logic [18:0] e;
        logic [15:0] ra, rb, msk;
        logic        rbin;

        // Reset state while RST is held.
        #12;
        chk("rst.in_ready", rdy_m, 0);
        chk("rst.out_valid", vld_m, 0);
        chk_res("rst", 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst.ready_rise", rdy_m, 1);

        // Directed 8-bit vectors.
        foreach (vecs[i]) begin
            start_op(0, vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(0);
            chk_res($sformatf("vec%0d", i), vecs[i].d, vecs[i].bw,
                    vecs[i].z, vecs[i].o);
            release_res();
        end

        // Backpressure: hold result while inputs wiggle.
        start_op(0, 16'h33, 16'h11, 1'b0);
        wait_done(0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a_s      = a_s + 16'h17;
            b_s      = b_s ^ 16'h5C;
            bin_s    = ~bin_s;
            @(posedge CLK);
            #1;
            chk_res("bp", 16'h22, 1'b0, 1'b0, 1'b0);
            chk("bp.out_valid", vld_m, 1);
            chk("bp.in_ready", rdy_m, 0);
        end
        in_valid = 1'b0;
        release_res();
        start_op(0, 16'h44, 16'h45, 1'b0);
        wait_done(0);
        chk_res("bp.next", 16'hFF, 1'b1, 1'b0, 1'b0);
        release_res();

        // Asynchronous abort in the third RUN cycle.
        start_op(0, 16'hAA, 16'h11, 1'b0);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        #2;
        RST = 1'b1;
        #1;
        chk_res("abort", 16'h0, 1'b0, 1'b0, 1'b0);
        chk("abort.out_valid", vld_m, 0);
        chk("abort.in_ready", rdy_m, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("abort.hold_valid", vld_m, 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort.ready_rise", rdy_m, 1);
        chk("abort.no_valid", vld_m, 0);
        start_op(0, 16'h10, 16'h01, 1'b0);
        wait_done(0);
        chk_res("post_abort", 16'h0F, 1'b0, 1'b0, 1'b0);
        release_res();

        // 16-bit, 4 bits per cycle.
        start_op(2, 16'h1000, 16'h0001, 1'b0);
        wait_done(2);
        chk_res("w16d4", 16'h0FFF, 1'b0, 1'b0, 1'b0);
        release_res();

        // Random sweep at DIGIT 1, 2 and 4.
        for (int s = 0; s < 3; s++) begin
            msk = (width_of(s) == 16) ? 16'hFFFF : 16'h00FF;
            for (int k = 0; k < 1000; k++) begin
                ra   = 16'($urandom) & msk;
                rb   = 16'($urandom) & msk;
                rbin = 1'($urandom);
                if (k == 0) begin
                    ra = '0;
                    rb = msk;
                    rbin = 1'b1;
                end
                e = model(width_of(s), ra, rb, rbin);
                start_op(s, ra, rb, rbin);
                wait_done(s);
                chk_res($sformatf("sweep%0d_%0d", s, k), e[15:0], e[16],
                        e[17], e[18]);
                release_res();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; SHALL divide WIDTH exactly, otherwise elaboration SHALL fail.
REQ-003 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 In_Valid  input  1  operands A, B, Bin are valid.
REQ-006 In_Ready  output  1  block can accept an operation.
REQ-007 A  input  WIDTH  minuend, unsigned.
REQ-008 B  input  WIDTH  subtrahend, unsigned.
REQ-009 Bin  input  1  borrow-in, for chaining.
REQ-010 Out_Valid  output  1  result is valid.
REQ-011 Out_Ready  input  1  consumer accepts the result.
REQ-012 Diff  output  WIDTH  result, A - B - Bin mod 2^WIDTH.
REQ-013 Borrow  output  1  borrow-out; 1 iff A < B + Bin, unsigned.
REQ-014 Zero  output  1  1 iff Diff == 0.
REQ-015 Ovf  output  1  two's-complement overflow of A - B - Bin.

Function
REQ-016 The FSM SHALL have three states:
- IDLE: In_Ready=1, Out_Valid=0.
- RUN: In_Ready=0, Out_Valid=0.
- DONE: In_Ready=0, Out_Valid=1.
REQ-017 Acceptance SHALL occur at a rising edge in IDLE with In_Valid=1.
- A, B and Bin SHALL be captured into internal registers at that edge.
- The digit counter SHALL be cleared to 0.
- The state SHALL move to RUN.
REQ-018 Once an operation is accepted, changes on A, B, Bin and In_Valid SHALL have no effect until the state returns to IDLE.
REQ-019 Each RUN edge SHALL process digit k (LSB first, bits [k*DIGIT +: DIGIT]):
- Compute {b, d} = A_k - B_k - borrow_reg.
- Write d into Diff bits [k*DIGIT +: DIGIT].
- Update borrow_reg to b.
- Increment k.
REQ-020 borrow_reg SHALL be loaded with Bin at acceptance.
REQ-021 After N = WIDTH/DIGIT RUN edges the state SHALL move to DONE, which gives the following timing:
- Out_Valid SHALL be high in the Nth cycle after the acceptance edge.
- Latency is N cycles, e.g. 8 for WIDTH=8, DIGIT=1.
REQ-022 Entering DONE SHALL set the flags:
- Borrow = final borrow_reg.
- Zero = (Diff == 0).
- Ovf = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]), using the captured operands.
REQ-023 In DONE, Diff, Borrow, Zero and Ovf SHALL hold stable while Out_Ready=0, for any number of cycles.
REQ-024 In DONE, a rising edge with Out_Ready=1 SHALL move the state to IDLE; In_Ready SHALL be 1 in the following cycle.
REQ-025 Diff and the flags SHALL keep their last values in IDLE and RUN, except that Diff bits are overwritten digit by digit during RUN.
- Consumers SHALL sample the result only when Out_Valid=1.
REQ-026 In_Ready and Out_Valid SHALL never be 1 in the same cycle.
- Sustained throughput is one operation per N+2 cycles.
REQ-027 The digit counter SHALL be $clog2(N+1) bits wide and SHALL never exceed N-1 in RUN.

Reset
REQ-028 While RST=1, the following SHALL hold:
- State SHALL be IDLE.
- Diff, Borrow, Zero, Ovf, Out_Valid, the counter and borrow_reg SHALL be 0.
- In_Ready SHALL be 0.
REQ-029 In_Ready SHALL rise in the first cycle after RST deasserts.
REQ-030 RST asserted during RUN or DONE SHALL abort the operation immediately, without waiting for a clock edge.
- No partial result SHALL become valid.

Verification
REQ-031 WIDTH=8, DIGIT=1, A=0x05, B=0x03, Bin=0 -> after 8 cycles Out_Valid=1, Diff=0x02, Borrow=0, Zero=0, Ovf=0.
REQ-032 WIDTH=8, A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Borrow=1. Then A=0x5A, B=0x5A, Bin=0 -> Diff=0x00, Zero=1. Then Bin=1 -> Diff=0xFF, Borrow=1, Zero=0.
REQ-033 WIDTH=8, A=0x80, B=0x01 -> Diff=0x7F, Ovf=1, Borrow=0. Also A=0x7F, B=0xFF -> Diff=0x80, Ovf=1, Borrow=1.
REQ-034 Backpressure: hold Out_Ready=0 for 5 cycles in DONE while toggling In_Valid, A and B -> outputs stable and In_Ready=0 throughout. Then Out_Ready=1 -> IDLE, and the next operation uses the new operands.
REQ-035 Assert RST in the 3rd RUN cycle -> all outputs 0 asynchronously and Out_Valid never rises. After release, In_Ready=1, and A=0x10, B=0x01 completes with Diff=0x0F.
REQ-036 WIDTH=16, DIGIT=4, A=0x1000, B=0x0001 -> Out_Valid after 4 cycles, Diff=0x0FFF, Borrow=0. A random sweep of 1000 operands at DIGIT in {1,2,4} SHALL match a reference model.
